// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: run/halt FSM, per-stage register enables,
// load-use stall and control-hazard flush decisions, cycle/retire counters.
module pipeline_ctrl #(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_req,
   input  logic             mem_read_id_ex,
   input  logic [4:0]       rd_id_ex,
   input  logic [4:0]       rs1_if_id,
   input  logic [4:0]       rs2_if_id,
   input  logic [31:0]      instr_if_id,
   input  logic             branch_ex_mem,
   input  logic             zero_flag_ex_mem,
   input  logic             jump_ex_mem,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             pipe_en,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             redirect,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam int unsigned      DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic             v_if_id_q, v_id_ex_q, v_ex_mem_q, v_mem_wb_q;
   logic [CNT_W-1:0] cycle_q, retired_q;

   logic halt_word;
   logic redirect_hit;
   logic load_use;
   logic halt_hit;
   logic launch;

   assign halt_word    = (instr_if_id == 32'h0000_0000);
   assign redirect_hit = v_ex_mem_q & ((branch_ex_mem & zero_flag_ex_mem) | jump_ex_mem);
   assign load_use     = mem_read_id_ex & v_id_ex_q & (rd_id_ex != 5'd0) &
                         ((rd_id_ex == rs1_if_id) | (rd_id_ex == rs2_if_id));
   assign halt_hit     = (v_if_id_q & halt_word) | halt_req;

   assign busy        = (state_q == StRun) || (state_q == StDrain);
   assign done        = (state_q == StDone);
   assign cycle_cnt   = cycle_q;
   assign retired_cnt = retired_q;

   // Next state and all enable/flush outputs, prioritised redirect > stall > halt.
   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      launch       = 1'b0;
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      pipe_en      = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      redirect     = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               launch  = 1'b1;
            end
         end
         StRun, StDrain: begin
            if (redirect_hit) begin
               // Also catches a wrong-path halt: the drain is abandoned.
               pc_en        = 1'b1;
               if_id_en     = 1'b1;
               pipe_en      = 1'b1;
               flush_if_id  = 1'b1;
               flush_id_ex  = 1'b1;
               flush_ex_mem = 1'b1;
               redirect     = 1'b1;
               state_d      = StRun;
            end else if (state_q == StDrain) begin
               pipe_en     = 1'b1;
               flush_if_id = 1'b1;
               if (drain_q == '0) begin
                  state_d = StDone;
               end else begin
                  drain_d = drain_q - 1'b1;
               end
            end else if (load_use) begin
               pipe_en     = 1'b1;
               flush_id_ex = 1'b1;
            end else if (halt_hit) begin
               // IF/ID is enabled so the flush turns the halt slot into a NOP.
               if_id_en    = 1'b1;
               pipe_en     = 1'b1;
               flush_if_id = 1'b1;
               state_d     = StDrain;
               drain_d     = DRAIN_LOAD;
            end else begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
               pipe_en  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state and drain countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   // Per-stage valid bits; the halt word is not an instruction and never leaves IF/ID.
   always_ff @(posedge clk) begin
      if (rst || launch) begin
         v_if_id_q  <= 1'b0;
         v_id_ex_q  <= 1'b0;
         v_ex_mem_q <= 1'b0;
         v_mem_wb_q <= 1'b0;
      end else begin
         if (if_id_en) begin
            v_if_id_q <= pc_en & ~flush_if_id;
         end
         if (pipe_en) begin
            v_id_ex_q  <= v_if_id_q & ~halt_word & ~flush_id_ex;
            v_ex_mem_q <= v_id_ex_q & ~flush_ex_mem;
            v_mem_wb_q <= v_ex_mem_q;
         end
      end
   end

   // Saturating cycle and retired-instruction counters, cleared on each launch.
   always_ff @(posedge clk) begin
      if (rst || launch) begin
         cycle_q   <= '0;
         retired_q <= '0;
      end else begin
         if (busy && (cycle_q != CNT_MAX)) begin
            cycle_q <= cycle_q + 1'b1;
         end
         if (pipe_en && v_mem_wb_q && (retired_q != CNT_MAX)) begin
            retired_q <= retired_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// stimulus against an instruction-tag reference model of the pipeline.
module tb_pipeline_ctrl;

   localparam int unsigned CW = 8;
   localparam int unsigned DC = 3;
   localparam logic [CW-1:0] SAT = '1;

   // Expected output patterns {pc_en, if_id_en, pipe_en, flush_if_id, flush_id_ex,
   // flush_ex_mem, redirect, busy, done}.
   localparam logic [8:0] P_OFF   = 9'b000_000_000;
   localparam logic [8:0] P_RUN   = 9'b111_000_010;
   localparam logic [8:0] P_STALL = 9'b001_010_010;
   localparam logic [8:0] P_HALT  = 9'b011_100_010;
   localparam logic [8:0] P_DRAIN = 9'b001_100_010;
   localparam logic [8:0] P_REDIR = 9'b111_111_110;
   localparam logic [8:0] P_DONE  = 9'b000_000_001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, halt_req, mem_read_id_ex;
   logic [4:0]    rd_id_ex, rs1_if_id, rs2_if_id;
   logic [31:0]   instr_if_id;
   logic          branch_ex_mem, zero_flag_ex_mem, jump_ex_mem;
   logic          pc_en, if_id_en, pipe_en, flush_if_id, flush_id_ex, flush_ex_mem;
   logic          redirect, busy, done;
   logic [CW-1:0] cycle_cnt, retired_cnt;
   logic [8:0]    obs;

   int checks = 0;
   int errors = 0;

   pipeline_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .mem_read_id_ex(mem_read_id_ex), .rd_id_ex(rd_id_ex),
      .rs1_if_id(rs1_if_id), .rs2_if_id(rs2_if_id), .instr_if_id(instr_if_id),
      .branch_ex_mem(branch_ex_mem), .zero_flag_ex_mem(zero_flag_ex_mem),
      .jump_ex_mem(jump_ex_mem), .pc_en(pc_en), .if_id_en(if_id_en), .pipe_en(pipe_en),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
      .redirect(redirect), .busy(busy), .done(done),
      .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
   );

   assign obs = {pc_en, if_id_en, pipe_en, flush_if_id, flush_id_ex, flush_ex_mem,
                 redirect, busy, done};

   // ---------------- reference model ----------------
   typedef enum int {MIdle, MRun, MDrain, MDone} mstate_e;
   localparam int ActNone = 0, ActRedir = 1, ActStall = 2, ActHalt = 3;
   localparam int ActRun = 4, ActDrain = 5, ActDone = 6;

   mstate_e m_state = MIdle;
   int m_left = 0;                       // drain cycles still to spend
   int m_slot[4] = '{-1, -1, -1, -1};    // tag in IF/ID, ID/EX, EX/MEM, MEM/WB; -1 = empty
   int m_tag = 0;
   int m_cyc = 0;
   int m_ret = 0;
   int m_max = 2**CW - 1;

   function automatic int model_action();
      bit redir, lu, hlt;
      redir = (m_slot[2] >= 0) && ((branch_ex_mem && zero_flag_ex_mem) || jump_ex_mem);
      lu = mem_read_id_ex && (m_slot[1] >= 0) && (rd_id_ex != 5'd0) &&
           ((rd_id_ex == rs1_if_id) || (rd_id_ex == rs2_if_id));
      hlt = ((m_slot[0] >= 0) && (instr_if_id == 32'h0)) || halt_req;
      if (m_state == MIdle) return ActNone;
      if (m_state == MDone) return ActDone;
      if (redir) return ActRedir;
      if (m_state == MDrain) return ActDrain;
      if (lu) return ActStall;
      if (hlt) return ActHalt;
      return ActRun;
   endfunction

   function automatic logic [8:0] model_out();
      case (model_action())
         ActRedir: return P_REDIR;
         ActStall: return P_STALL;
         ActHalt:  return P_HALT;
         ActRun:   return P_RUN;
         ActDrain: return P_DRAIN;
         ActDone:  return P_DONE;
         default:  return P_OFF;
      endcase
   endfunction

   // Advance the model by one clock using the inputs present before the edge.
   task automatic tick();
      int a;
      logic [8:0] o;
      int s[4];
      a = model_action();
      o = model_out();
      s = m_slot;
      if (rst) begin
         m_state = MIdle; m_cyc = 0; m_ret = 0; m_left = 0;
         for (int i = 0; i < 4; i++) m_slot[i] = -1;
      end else if (m_state == MIdle || m_state == MDone) begin
         if (start) begin
            m_state = MRun; m_cyc = 0; m_ret = 0;
            for (int i = 0; i < 4; i++) m_slot[i] = -1;
         end
      end else begin
         if (m_cyc < m_max) m_cyc++;
         if (o[6] && s[3] >= 0 && m_ret < m_max) m_ret++;
         if (o[6]) begin
            m_slot[3] = s[2];
            m_slot[2] = o[3] ? -1 : s[1];
            // The halt word is a marker, not an instruction: it never moves on.
            m_slot[1] = (o[4] || instr_if_id == 32'h0) ? -1 : s[0];
         end
         if (o[7]) begin
            if (o[8] && !o[5]) begin
               m_slot[0] = m_tag;
               m_tag++;
            end else begin
               m_slot[0] = -1;
            end
         end
         case (a)
            ActRedir: m_state = MRun;
            ActHalt: begin
               m_state = MDrain;
               m_left  = DC;
            end
            ActDrain: begin
               m_left--;
               if (m_left == 0) m_state = MDone;
            end
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      start = 1'b0; halt_req = 1'b0; mem_read_id_ex = 1'b0;
      rd_id_ex = 5'd0; rs1_if_id = 5'd0; rs2_if_id = 5'd0;
      instr_if_id = 32'h0000_0013;
      branch_ex_mem = 1'b0; zero_flag_ex_mem = 1'b0; jump_ex_mem = 1'b0;
   endtask

   // Reset, then launch; returns at the first RUN cycle.
   task automatic begin_run();
      quiet_inputs();
      rst = 1'b1; tick();
      rst = 1'b0; start = 1'b1; tick();
      start = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      quiet_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== P_OFF) begin
         errors++; $display("FAIL reset_outputs: got %b want %b", obs, P_OFF);
      end
      checks++;
      if (cycle_cnt !== '0 || retired_cnt !== '0) begin
         errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, retired_cnt);
      end
      tick();
   endtask

   task automatic test_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== P_RUN || obs !== model_out()) begin
            errors++; $display("FAIL start_out[%0d]: got %b want %b", k, obs, P_RUN);
         end
         checks++;
         if (cycle_cnt !== k[CW-1:0]) begin
            errors++; $display("FAIL start_cycle[%0d]: got %0d want %0d", k, cycle_cnt, k);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      int stalls = 0;
      mem_read_id_ex = 1'b1; rd_id_ex = 5'd5; rs1_if_id = 5'd5; rs2_if_id = 5'd0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== model_out() || obs !== ((k == 0) ? P_STALL : P_RUN)) begin
            errors++; $display("FAIL load_use[%0d]: got %b want %b", k, obs, model_out());
         end
         if (!pc_en) stalls++;
         tick();
      end
      checks++;
      if (stalls != 1) begin
         errors++; $display("FAIL load_use_bubbles: got %0d want 1", stalls);
      end
      rd_id_ex = 5'd0; rs1_if_id = 5'd0;
      @(negedge clk);
      checks++;
      if (obs !== P_RUN) begin
         errors++; $display("FAIL load_use_x0: got %b want %b", obs, P_RUN);
      end
      tick();
      quiet_inputs();
   endtask

   task automatic test_branch();
      int base;
      for (int k = 0; k < 5; k++) tick();
      branch_ex_mem = 1'b1; zero_flag_ex_mem = 1'b1;
      mem_read_id_ex = 1'b1; rd_id_ex = 5'd7; rs2_if_id = 5'd7;
      @(negedge clk);
      checks++;
      if (obs !== P_REDIR || obs !== model_out()) begin
         errors++; $display("FAIL branch_redirect: got %b want %b", obs, P_REDIR);
      end
      base = m_ret;
      tick();
      quiet_inputs();
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         checks++;
         if (obs !== model_out() || retired_cnt !== m_ret[CW-1:0]) begin
            errors++;
            $display("FAIL branch_follow[%0d]: got %b/%0d want %b/%0d", j, obs, retired_cnt,
                     model_out(), m_ret);
         end
         if (j == 5) begin
            checks++;
            if (retired_cnt !== 8'(base + 2)) begin
               errors++; $display("FAIL branch_penalty: got %0d want %0d", retired_cnt, base + 2);
            end
         end
         tick();
      end
   endtask

   // Four instructions then the halt word; redirect_at>0 injects a jump in that cycle.
   task automatic halt_seq(input string name, input int redirect_at, input int rst_at);
      logic [8:0] want;
      begin_run();
      for (int c = 1; c <= 11; c++) begin
         quiet_inputs();
         if (c >= 6) instr_if_id = 32'h0;
         if (c == redirect_at) jump_ex_mem = 1'b1;
         if (c > redirect_at && redirect_at > 0) instr_if_id = 32'h0000_0013;
         rst = (c == rst_at);
         if (redirect_at > 0)     want = (c == 6) ? P_HALT : (c == 7) ? P_REDIR : P_RUN;
         else if (c > rst_at)     want = P_OFF;
         else if (c <= 5)         want = P_RUN;
         else if (c == 6)         want = P_HALT;
         else if (c <= 9)         want = P_DRAIN;
         else                     want = P_DONE;
         @(negedge clk);
         checks++;
         if (obs !== want || obs !== model_out()) begin
            errors++; $display("FAIL %s_out[%0d]: got %b want %b", name, c, obs, want);
         end
         if (c == 10 && rst_at > 10 && redirect_at == 0) begin
            checks++;
            if (retired_cnt !== 8'd4 || cycle_cnt !== 8'd9) begin
               errors++;
               $display("FAIL %s_counts: got %0d/%0d want 4/9", name, retired_cnt, cycle_cnt);
            end
         end
         if (c == rst_at + 1) begin
            checks++;
            if (cycle_cnt !== '0 || retired_cnt !== '0) begin
               errors++;
               $display("FAIL %s_rst_counts: got %0d/%0d want 0/0", name, cycle_cnt, retired_cnt);
            end
         end
         tick();
      end
      rst = 1'b0;
   endtask

   task automatic test_halt();
      halt_seq("halt", 0, 99);
   endtask

   task automatic test_drain_redirect();
      halt_seq("drain_redir", 7, 99);
   endtask

   task automatic test_reset_mid_drain();
      halt_seq("rst_drain", 0, 8);
      quiet_inputs();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (obs !== P_RUN || cycle_cnt !== k[CW-1:0]) begin
            errors++;
            $display("FAIL restart[%0d]: got %b/%0d want %b/%0d", k, obs, cycle_cnt, P_RUN, k);
         end
         tick();
      end
   endtask

   task automatic test_saturate();
      begin_run();
      for (int k = 0; k < 299; k++) tick();
      @(negedge clk);
      checks++;
      if (cycle_cnt !== SAT || retired_cnt !== SAT) begin
         errors++;
         $display("FAIL saturate: got %0d/%0d want %0d/%0d", cycle_cnt, retired_cnt, SAT, SAT);
      end
      tick();
   endtask

   task automatic test_random();
      begin_run();
      for (int k = 0; k < 2000; k++) begin
         rst              = ($urandom_range(0, 199) == 0);
         start            = ($urandom_range(0, 19) == 0);
         halt_req         = ($urandom_range(0, 39) == 0);
         mem_read_id_ex   = $urandom_range(0, 1) == 1;
         rd_id_ex         = 5'($urandom_range(0, 3));
         rs1_if_id        = 5'($urandom_range(0, 3));
         rs2_if_id        = 5'($urandom_range(0, 3));
         instr_if_id      = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom() | 32'h1);
         branch_ex_mem    = ($urandom_range(0, 5) == 0);
         zero_flag_ex_mem = $urandom_range(0, 1) == 1;
         jump_ex_mem      = ($urandom_range(0, 11) == 0);
         @(negedge clk);
         checks++;
         if (obs !== model_out()) begin
            errors++; $display("FAIL rand_out[%0d]: got %b want %b", k, obs, model_out());
         end
         checks++;
         if (cycle_cnt !== m_cyc[CW-1:0]) begin
            errors++; $display("FAIL rand_cycle[%0d]: got %0d want %0d", k, cycle_cnt, m_cyc);
         end
         checks++;
         if (retired_cnt !== m_ret[CW-1:0]) begin
            errors++; $display("FAIL rand_retired[%0d]: got %0d want %0d", k, retired_cnt, m_ret);
         end
         tick();
      end
      rst = 1'b0;
      quiet_inputs();
   endtask

   initial begin
      rst = 1'b1;
      quiet_inputs();
      test_reset();
      test_start();
      test_load_use();
      test_branch();
      test_halt();
      test_drain_redirect();
      test_reset_mid_drain();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencing controller for the 5-stage RISC-V pipeline. It owns run/halt state, the per-stage register enables, and the flush/bubble controls.
- Decides load-use stalls and control-hazard flushes (taken branch or jump resolved in EX/MEM).
- Drains the pipeline on a halt instruction.
- Keeps cycle and retired-instruction counters for the testbench.
- Sits beside the hazard/forwarding logic and drives the enable/clear inputs of all pipeline registers and the PC.

Parameters:
CNT_W, 32, width of cycle_cnt and retired_cnt (saturating).
DRAIN_CYCLES, 3, cycles spent in DRAIN so that instructions older than the halt reach WB.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  reset, synchronous and active-high.
start  in  1  one-cycle pulse; begins execution from IDLE or DONE.
halt_req  in  1  external halt request, level.
mem_read_id_ex  in  1  ID/EX instruction is a load.
rd_id_ex  in  5  destination register in ID/EX.
rs1_if_id  in  5  source register 1 in IF/ID.
rs2_if_id  in  5  source register 2 in IF/ID.
instr_if_id  in  32  IF/ID instruction word; halt is 32'h0000_0000.
branch_ex_mem  in  1  EX/MEM holds a branch.
zero_flag_ex_mem  in  1  EX/MEM branch condition.
jump_ex_mem  in  1  EX/MEM holds a jump.
pc_en  out  1  PC update enable.
if_id_en  out  1  IF/ID register enable.
pipe_en  out  1  enable for ID/EX, EX/MEM and MEM/WB registers.
flush_if_id  out  1  clear IF/ID to a NOP on the next edge.
flush_id_ex  out  1  clear ID/EX control bits, inserting a bubble.
flush_ex_mem  out  1  clear EX/MEM control bits.
redirect  out  1  PC takes the branch or jump target this cycle.
busy  out  1  state is RUN or DRAIN.
done  out  1  state is DONE.
cycle_cnt  out  CNT_W  cycles spent in RUN plus DRAIN.
retired_cnt  out  CNT_W  valid instructions leaving MEM/WB.

Behaviour:
- States: IDLE, RUN, DRAIN, DONE. State is 2 bits and registered.
- Reset (rst=1 at an edge):
  - state=IDLE, cycle_cnt=0, retired_cnt=0, internal valid bits v_if_id/v_id_ex/v_ex_mem/v_mem_wb=0, drain counter=0.
  - Reset overrides all events in the same cycle, including mid-RUN or mid-DRAIN.
- Outputs:
  - All enables, flushes and redirect are combinational from state plus inputs.
  - In IDLE/DONE: every output is 0 except done (1 in DONE).
- IDLE to RUN on start. DONE to RUN on start; counters clear on that same edge.
- RUN, evaluated in priority order:
  1. redirect = branch_ex_mem&zero_flag_ex_mem | jump_ex_mem, gated by v_ex_mem.
     - If redirect: pc_en=1, if_id_en=1, pipe_en=1, flush_if_id=1, flush_id_ex=1, flush_ex_mem=1.
     - This costs a 3-cycle penalty. It overrides any stall or halt seen in the same cycle.
  2. Load-use stall:
     - Condition: mem_read_id_ex & v_id_ex & rd_id_ex!=0 & (rd_id_ex==rs1_if_id | rd_id_ex==rs2_if_id).
     - Response: pc_en=0, if_id_en=0, pipe_en=1, flush_id_ex=1.
     - Exactly 1 bubble per load-use pair.
  3. Halt:
     - Condition: (v_if_id & instr_if_id==0) | halt_req.
     - Response: flush_if_id=1, pc_en=0, pipe_en=1, go to DRAIN, drain counter=DRAIN_CYCLES-1.
  4. Otherwise: pc_en=if_id_en=pipe_en=1, no flushes.
- DRAIN:
  - pc_en=0, if_id_en=0, pipe_en=1, flush_if_id=1. Decrement the drain counter each cycle; at 0 go to DONE.
  - If a valid redirect occurs in DRAIN, the halt was wrong-path: apply the RUN redirect response and return to RUN. halt_req still high re-enters DRAIN next cycle.
- Valid tracking:
  - v_if_id<=pc_en & ~flush_if_id when if_id_en; v_id_ex<=v_if_id & ~flush_id_ex; v_ex_mem<=v_id_ex & ~flush_ex_mem; v_mem_wb<=v_ex_mem.
  - Values held when the corresponding enable is 0. All cleared on entering RUN from IDLE/DONE.
- Counters:
  - cycle_cnt +1 each cycle in RUN/DRAIN.
  - retired_cnt +1 when v_mem_wb & pipe_en.
  - Both saturate at all-ones and hold in IDLE/DONE.
- start while busy is ignored.

Test Plan:
1. rst=1 for 2 cycles, then start pulse → busy=1 next cycle, pc_en=1, cycle_cnt counts 1,2,3…; all flushes 0.
2. Load-use x5 (rd_id_ex=5, mem_read_id_ex=1, rs1_if_id=5) → exactly 1 cycle of pc_en=0, if_id_en=0, flush_id_ex=1. With rd_id_ex=0 → no stall.
3. Taken branch (branch_ex_mem=1, zero_flag_ex_mem=1, v_ex_mem=1) concurrent with load-use → redirect=1 and all three flushes=1, no stall. retired_cnt excludes the 3 flushed slots.
4. Halt word in IF/ID after 4 valid instructions → DRAIN for 3 cycles, then done=1, busy=0, retired_cnt=4.
5. Jump in EX/MEM during DRAIN cycle 1 → redirect=1, state returns to RUN, done stays 0.
6. rst asserted mid-DRAIN → next cycle state=IDLE, counters 0, all outputs 0. A second start resumes with counters from 0.
